// File: rtl/alu_operand_sequencer_pkg.sv
// Shared widths and FSM state encoding for the ALU operand sequencer slice.
package alu_seq_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;
    localparam int SH_W   = 2;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OP  = 2'd2,
        S_RUN = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Switch/button inputs and registered ALU-facing outputs of the operand sequencer.
interface alu_operand_sequencer_if;
    import alu_seq_pkg::*;

    logic [DATA_W-1:0] sw;
    logic              btnC;
    logic              btnU;
    logic              btnD;
    logic              btnL;
    logic              btnR;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [OP_W-1:0]   alu_ctrl;
    logic [SH_W-1:0]   shamt;
    logic [1:0]        state;
    logic              valid;

    modport master (
        output sw, btnC, btnU, btnD, btnL, btnR,
        input  a_q, b_q, alu_ctrl, shamt, state, valid
    );

    modport slave (
        input  sw, btnC, btnU, btnD, btnL, btnR,
        output a_q, b_q, alu_ctrl, shamt, state, valid
    );

endinterface

// File: rtl/alu_operand_sequencer_btn_conditioner.sv
// Raw push-button -> single-cycle press pulse: 2-flop sync, optional debounce, rising edge.
// Debounce stage is present only when SEQ_DEBOUNCE_EN is defined.
module btn_conditioner #(
    parameter int DB_CYCLES = 200000,
    parameter int DB_CNT_W  = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic prev_q;
    logic pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef SEQ_DEBOUNCE_EN
    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

    logic                level_q;
    logic [DB_CNT_W-1:0] cnt_q;

    // Any cycle where the input agrees with the held level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else if (sync2_q == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            level_q <= sync2_q;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_q + DB_CNT_W'(1);
        end
    end

    assign level = level_q;
`else
    logic unusedCfg;
    assign unusedCfg = ^{DB_CYCLES, DB_CNT_W};
    assign level     = sync2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= level;
            pulse_q <= level & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Operand load sequencer in front of the ALU: A, then B, then op/shift select, then run.
// Define SEQ_DEBOUNCE_EN to insert the DB_CYCLES debouncer in each button path.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DB_CYCLES = 200000,
    parameter int DB_CNT_W  = 18
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_operand_sequencer_if.slave  bus
);

    logic [1:0]        rstSync_q;
    logic              rstInt_n;
    logic [4:0]        btnRaw;
    logic [4:0]        pulse;
    logic              pC;
    logic              pU;
    logic              pD;
    logic              pL;
    logic              pR;

    logic [DATA_W-1:0] aOp_q;
    logic [DATA_W-1:0] bOp_q;
    logic [OP_W-1:0]   aluCtrl_q;
    logic [SH_W-1:0]   shamt_q;
    seq_state_e        state_q;
    logic              valid_q;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign rstInt_n = rstSync_q[1];

    assign btnRaw = {bus.btnR, bus.btnL, bus.btnD, bus.btnU, bus.btnC};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_conditioner #(
            .DB_CYCLES (DB_CYCLES),
            .DB_CNT_W  (DB_CNT_W)
        ) u_cond (
            .clk     (clk),
            .rst_n   (rstInt_n),
            .btn_i   (btnRaw[i]),
            .pulse_o (pulse[i])
        );
    end

    assign pC = pulse[0];
    assign pU = pulse[1];
    assign pD = pulse[2];
    assign pL = pulse[3];
    assign pR = pulse[4];

    // Confirm wins over every adjust pulse; opposing adjust pulses cancel.
    always_ff @(posedge clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            aOp_q     <= '0;
            bOp_q     <= '0;
            aluCtrl_q <= '0;
            shamt_q   <= '0;
            state_q   <= S_A;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                S_A: begin
                    if (pC) begin
                        aOp_q   <= bus.sw;
                        state_q <= S_B;
                    end
                end
                S_B: begin
                    if (pC) begin
                        bOp_q   <= bus.sw;
                        state_q <= S_OP;
                    end
                end
                S_OP: begin
                    if (pC) begin
                        state_q <= S_RUN;
                        valid_q <= 1'b1;
                    end else begin
                        if (pU && !pD) begin
                            aluCtrl_q <= aluCtrl_q + OP_W'(1);
                        end else if (pD && !pU) begin
                            aluCtrl_q <= aluCtrl_q - OP_W'(1);
                        end
                        if (pL && !pR) begin
                            shamt_q <= shamt_q + SH_W'(1);
                        end else if (pR && !pL) begin
                            shamt_q <= shamt_q - SH_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (pC) begin
                        state_q <= S_A;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_A;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_q      = aOp_q;
    assign bus.b_q      = bOp_q;
    assign bus.alu_ctrl = aluCtrl_q;
    assign bus.shamt    = shamt_q;
    assign bus.state    = state_q;
    assign bus.valid    = valid_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer against a press-level reference model.
module tb_alu_operand_sequencer;

    localparam int HOLD   = 12;
    localparam int SETTLE = 12;
    localparam logic [4:0] B_C = 5'b00001;
    localparam logic [4:0] B_U = 5'b00010;
    localparam logic [4:0] B_D = 5'b00100;
    localparam logic [4:0] B_L = 5'b01000;
    localparam logic [4:0] B_R = 5'b10000;

    logic clk = 1'b0;
    logic rst_n;

    int numChecks = 0;
    int numPass   = 0;

    int mState;
    int mA;
    int mB;
    int mCtrl;
    int mSh;

    alu_operand_sequencer_if seqIf ();

    alu_operand_sequencer #(
        .DB_CYCLES (4),
        .DB_CNT_W  (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (seqIf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            numPass++;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".a"},     32'(seqIf.a_q),      32'(mA));
        checkOutput({tag, ".b"},     32'(seqIf.b_q),      32'(mB));
        checkOutput({tag, ".ctrl"},  32'(seqIf.alu_ctrl), 32'(mCtrl));
        checkOutput({tag, ".shamt"}, 32'(seqIf.shamt),    32'(mSh));
        checkOutput({tag, ".state"}, 32'(seqIf.state),    32'(mState));
        checkOutput({tag, ".valid"}, 32'(seqIf.valid),    (mState == 3) ? 32'd1 : 32'd0);
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setButtons(input logic [4:0] mask);
        seqIf.btnC = mask[0];
        seqIf.btnU = mask[1];
        seqIf.btnD = mask[2];
        seqIf.btnL = mask[3];
        seqIf.btnR = mask[4];
    endtask

    task automatic modelReset();
        mState = 0;
        mA = 0;
        mB = 0;
        mCtrl = 0;
        mSh = 0;
    endtask

    // One press event: confirm advances the sequence, otherwise adjusts only in the op phase.
    task automatic modelPress(input logic [4:0] mask, input logic [7:0] swVal);
        int u, d, l, r;
        u = int'(mask[1]);
        d = int'(mask[2]);
        l = int'(mask[3]);
        r = int'(mask[4]);
        if (mask[0]) begin
            case (mState)
                0: begin mA = int'(swVal); mState = 1; end
                1: begin mB = int'(swVal); mState = 2; end
                2: mState = 3;
                default: mState = 0;
            endcase
        end else if (mState == 2) begin
            mCtrl = (mCtrl + 8 + u - d) % 8;
            mSh   = (mSh + 4 + l - r) % 4;
        end
    endtask

    task automatic applyStimulus(input logic [4:0] mask, input logic [7:0] swVal, input int holdCycles);
        seqIf.sw = swVal;
        setButtons(mask);
        stepCycles(holdCycles);
        setButtons(5'b0);
        stepCycles(SETTLE);
        modelPress(mask, swVal);
    endtask

    task automatic doReset();
        setButtons(5'b0);
        rst_n = 1'b0;
        stepCycles(3);
        modelReset();
        rst_n = 1'b1;
        stepCycles(4);
    endtask

    initial begin
        rst_n    = 1'b0;
        seqIf.sw = 8'h00;
        setButtons(5'b0);
        modelReset();
        stepCycles(3);
        checkAll("reset");
        rst_n = 1'b1;
        stepCycles(4);

        // Full load sequence
        applyStimulus(B_C, 8'h3C, HOLD);
        checkOutput("seq.loadA", 32'(seqIf.a_q), 32'h3C);
        applyStimulus(B_C, 8'hA5, HOLD);
        repeat (3) applyStimulus(B_U, 8'h00, HOLD);
        repeat (2) applyStimulus(B_L, 8'h00, HOLD);
        applyStimulus(B_C, 8'h00, HOLD);
        checkOutput("seq.a",     32'(seqIf.a_q),      32'h3C);
        checkOutput("seq.b",     32'(seqIf.b_q),      32'hA5);
        checkOutput("seq.ctrl",  32'(seqIf.alu_ctrl), 32'd3);
        checkOutput("seq.shamt", 32'(seqIf.shamt),    32'd2);
        checkOutput("seq.state", 32'(seqIf.state),    32'd3);
        checkOutput("seq.valid", 32'(seqIf.valid),    32'd1);

        // Wrap-around from reset values
        doReset();
        applyStimulus(B_C, 8'h11, HOLD);
        applyStimulus(B_C, 8'h22, HOLD);
        applyStimulus(B_D, 8'h00, HOLD);
        checkOutput("wrap.ctrlDown", 32'(seqIf.alu_ctrl), 32'd7);
        applyStimulus(B_R, 8'h00, HOLD);
        checkOutput("wrap.shamtDown", 32'(seqIf.shamt), 32'd3);
        applyStimulus(B_U, 8'h00, HOLD);
        checkOutput("wrap.ctrlUp", 32'(seqIf.alu_ctrl), 32'd0);
        checkAll("wrap");

        // Long hold gives exactly one step
        applyStimulus(B_U, 8'h00, 100);
        checkAll("hold");

        // Single-cycle glitch train
        for (int i = 0; i < 6; i++) begin
            seqIf.btnU = 1'b1;
            stepCycles(1);
            seqIf.btnU = 1'b0;
            stepCycles(1);
        end
        stepCycles(SETTLE);
`ifndef SEQ_DEBOUNCE_EN
        mCtrl = (mCtrl + 6) % 8;
`endif
        checkAll("bounce");

        // Simultaneous pulses
        applyStimulus(B_U | B_D, 8'h00, HOLD);
        checkAll("upDown");
        applyStimulus(B_L | B_R | B_U, 8'h00, HOLD);
        checkAll("leftRightUp");
        applyStimulus(B_C | B_U, 8'h00, HOLD);
        checkAll("confirmUp");

        // Asynchronous reset in the op phase
        applyStimulus(B_C, 8'h5A, HOLD);
        applyStimulus(B_C, 8'h6B, HOLD);
        applyStimulus(B_C, 8'h7C, HOLD);
        for (int i = 0; i < 8 && mCtrl != 5; i++) begin
            applyStimulus(B_U, 8'h00, HOLD);
        end
        checkOutput("preReset.ctrl", 32'(seqIf.alu_ctrl), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("asyncReset");
        stepCycles(2);
        rst_n = 1'b1;
        stepCycles(4);
        checkAll("afterReset");

        // Run -> A retains operands; sw activity without a press is ignored
        applyStimulus(B_C, 8'hC3, HOLD);
        applyStimulus(B_C, 8'h96, HOLD);
        applyStimulus(B_C, 8'h00, HOLD);
        applyStimulus(B_C, 8'h00, HOLD);
        checkAll("runToA");
        for (int i = 0; i < 10; i++) begin
            seqIf.sw = 8'($urandom);
            stepCycles(3);
        end
        stepCycles(SETTLE);
        checkAll("swNoPress");

        // Randomized presses against the model
        for (int i = 0; i < 50; i++) begin
            logic [4:0] mask;
            logic [7:0] swVal;
            swVal = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                mask = B_C;
            end else begin
                mask = 5'($urandom_range(1, 31));
                if ($urandom_range(0, 1) == 1) mask[0] = 1'b0;
            end
            applyStimulus(mask, swVal, HOLD);
            checkAll($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", numPass, numChecks);
        $finish;
    end

endmodule
